dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_rr_select.sv | 23 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared AddrMode codes, sequencer state encoding and mode decode helpers for the
// data-memory arbiter.
package dmem_pkg;

    localparam logic [3:0] MODE_LB   = 4'b0000;
    localparam logic [3:0] MODE_LH   = 4'b0001;
    localparam logic [3:0] MODE_LW   = 4'b0010;
    localparam logic [3:0] MODE_LBU  = 4'b0011;
    localparam logic [3:0] MODE_LHU  = 4'b0100;
    localparam logic [3:0] MODE_SB   = 4'b0101;
    localparam logic [3:0] MODE_SH   = 4'b0110;
    localparam logic [3:0] MODE_SW   = 4'b0111;
    localparam logic [3:0] MODE_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic is_store(input logic [3:0] mode);
        return (mode == MODE_SB) || (mode == MODE_SH) || (mode == MODE_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] mode);
        return (mode == MODE_LB) || (mode == MODE_LH) || (mode == MODE_LW) ||
               (mode == MODE_LBU) || (mode == MODE_LHU);
    endfunction

    // Access width in bytes; 0 for IDLE and for illegal codes.
    function automatic logic [2:0] access_size(input logic [3:0] mode);
        case (mode)
            MODE_LB, MODE_LBU, MODE_SB: return 3'd1;
            MODE_LH, MODE_LHU, MODE_SH: return 3'd2;
            MODE_LW, MODE_SW:           return 3'd4;
            default:                    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_select.sv
// Combinational two-way round-robin pick with lock override; one-hot select, zero
// when nothing is valid. Pure logic, no latency, no backpressure of its own.
module dmem_rr_select (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       lock_held,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        if (lock_held && valid[last_grant]) begin
            sel = last_grant ? 2'b10 : 2'b01;
        end else if (valid == 2'b01) begin
            sel = 2'b01;
        end else if (valid == 2'b10) begin
            sel = 2'b10;
        end else if (valid == 2'b11) begin
            sel = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter and access sequencer for the data memory: 2-cycle latency for every
// request, one request per 2 cycles; requesters hold req_* until req_ready.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ADDR_REAL_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][3:0]            req_mode,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]                 req_lock,
    output logic [1:0]                 rsp_valid,
    output logic                       rsp_err,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [3:0]                 mem_mode,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    state_t                state;
    logic                  last_grant;
    logic                  lock_held;
    logic [3:0]            lat_mode;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_port;
    logic                  lat_err;

    logic [1:0]            sel;
    logic                  can_accept;
    logic                  accept;
    logic                  acc_port;
    logic [3:0]            acc_mode;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [2:0]            acc_size;
    logic                  acc_err;

    dmem_rr_select u_select (
        .valid      (req_valid),
        .last_grant (last_grant),
        .lock_held  (lock_held),
        .sel        (sel)
    );

    assign can_accept = (state == ST_IDLE) || (state == ST_RESP);
    assign req_ready  = (can_accept && !rst) ? sel : 2'b00;
    assign accept     = |req_ready;

    // Decode the request being accepted this cycle; only meaningful when accept is high.
    always_comb begin
        acc_port = req_ready[1];
        acc_mode = req_mode[acc_port];
        acc_addr = req_addr[acc_port];
        acc_size = access_size(acc_mode);
        acc_err  = 1'b0;
        if (acc_size == 3'd0 && acc_mode != MODE_IDLE) acc_err = 1'b1;
        if (acc_size == 3'd2 && acc_addr[0])           acc_err = 1'b1;
        if (acc_size == 3'd4 && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
        if (acc_addr[ADDR_WIDTH-1:ADDR_REAL_WIDTH] != '0) acc_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            lock_held  <= 1'b0;
            lat_mode   <= MODE_IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_port   <= 1'b0;
            lat_err    <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state <= ST_ACCESS;
                ST_ACCESS: state <= ST_RESP;
                ST_RESP:   state <= accept ? ST_ACCESS : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            if (accept) begin
                lat_mode   <= acc_mode;
                lat_addr   <= acc_addr;
                lat_wdata  <= req_wdata[acc_port];
                lat_port   <= acc_port;
                lat_err    <= acc_err;
                last_grant <= acc_port;
                lock_held  <= req_lock[acc_port];
            end else if (can_accept && lock_held && !req_valid[last_grant]) begin
                // Locked owner walked away: release so the other port is not starved.
                lock_held <= 1'b0;
            end

            if (state == ST_ACCESS) begin
                rsp_valid <= lat_port ? 2'b10 : 2'b01;
                rsp_err   <= lat_err;
                rsp_rdata <= (!lat_err && is_load(lat_mode)) ? mem_rdata : '0;
            end else begin
                rsp_valid <= 2'b00;
            end
        end
    end

    // Reset gates the mode combinationally so a store caught mid-ACCESS never commits.
    always_comb begin
        mem_mode  = MODE_IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ST_ACCESS) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (!lat_err && !rst) mem_mode = lat_mode;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drivers push expected responses into a scoreboard,
// a negedge monitor pops and compares; a byte-array memory model sits on mem_*.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   req_mode;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        req_lock;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [3:0]        mem_mode;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_REAL_WIDTH(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- memory model (128 KB, address bits [16:0]) ----------------
    logic [7:0]  mem [0:131071];
    logic        mem_clr = 1'b1;
    logic        pk_en;
    logic [16:0] pk_a;
    logic [7:0]  pk_d;
    logic [16:0] ma;
    logic [7:0]  b0, b1, b2, b3;

    assign ma = mem_addr[16:0];
    assign b0 = mem[ma];
    assign b1 = mem[ma + 17'd1];
    assign b2 = mem[ma + 17'd2];
    assign b3 = mem[ma + 17'd3];

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_mode)
            MODE_LB:  mem_rdata = {{24{b0[7]}}, b0};
            MODE_LH:  mem_rdata = {{16{b1[7]}}, b1, b0};
            MODE_LW:  mem_rdata = {b3, b2, b1, b0};
            MODE_LBU: mem_rdata = {24'h0, b0};
            MODE_LHU: mem_rdata = {16'h0, b1, b0};
            default:  mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 131072; i++) mem[i] <= 8'h00;
        end else if (pk_en) begin
            mem[pk_a] <= pk_d;
        end else begin
            case (mem_mode)
                MODE_SB: mem[ma] <= mem_wdata[7:0];
                MODE_SH: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[ma + 17'd1] <= mem_wdata[15:8];
                end
                MODE_SW: begin
                    mem[ma]         <= mem_wdata[7:0];
                    mem[ma + 17'd1] <= mem_wdata[15:8];
                    mem[ma + 17'd2] <= mem_wdata[23:16];
                    mem[ma + 17'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    typedef struct {
        int         cyc;
        logic [3:0] mode;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   glog[$];
    int   gcyc[$];

    always @(negedge clk) begin
        if (!mem_clr) begin
            if (acc_q.size() > 0 && acc_q[0].cyc + 1 == cyc) begin
                chk("access_mem_mode", {28'h0, mem_mode}, {28'h0, acc_q[0].mode});
                void'(acc_q.pop_front());
            end else begin
                chk("idle_mem_mode", {28'h0, mem_mode}, {28'h0, MODE_IDLE});
            end
            if (exp_q.size() > 0 && exp_q[0].cyc + 2 == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_valid", {30'h0, rsp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end else if (rsp_valid !== 2'b00) begin
                chk("rsp_valid_unexpected", {30'h0, rsp_valid}, 32'd0);
            end
        end
    end

    task automatic drive(input int p, input logic [3:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock,
                         input logic err, input logic [31:0] rdata);
        logic got;
        req_mode[p]  = mode;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_lock[p]  = lock;
        req_valid[p] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout port %0d: req_ready never seen, required within 50 cycles", p);
        end else begin
            exp_q.push_back('{p, err, rdata, cyc});
            acc_q.push_back('{cyc, err ? MODE_IDLE : mode});
            glog.push_back(p);
            gcyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (exp_q.size() > 0 || acc_q.size() > 0); k++) @(negedge clk);
        if (exp_q.size() > 0 || acc_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string nm, input int n, input logic [7:0] seq);
        chk({nm, "_count"}, glog.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < glog.size()) chk({nm, "_order"}, glog[i], {31'h0, seq[i]});
        end
        glog.delete();
        gcyc.delete();
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        pk_a  = a;
        pk_d  = d;
        pk_en = 1'b1;
        @(posedge clk);
        #1;
        pk_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_mode  = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = 2'b00;
        pk_en     = 1'b0;
        pk_a      = '0;
        pk_d      = '0;
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        poke(17'h10000, 8'hEF);
        poke(17'h10001, 8'hBE);
        poke(17'h10002, 8'hAD);
        poke(17'h10003, 8'hDE);
        poke(17'h00020, 8'h80);
        poke(17'h00040, 8'h5A);

        // Reset state, with both ports requesting while rst is high.
        req_valid = 2'b11;
        @(negedge clk);
        chk("reset_req_ready", {30'h0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'h0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;

        // Single CPU word load.
        drive(0, MODE_LW, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        drain();
        check_grants("t1_grant", 1, 8'b0);

        // Tie from reset: CPU first, DMA two cycles later, then read back.
        pulse_reset();
        fork
            drive(0, MODE_SW, 32'h100, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
            drive(1, MODE_SW, 32'h104, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        join
        drain();
        if (gcyc.size() == 2) chk("t2_grant_gap", gcyc[1] - gcyc[0], 32'd2);
        check_grants("t2_grant", 2, 8'b10);
        drive(0, MODE_LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h1111_1111);
        drive(0, MODE_LW, 32'h104, 32'h0, 1'b0, 1'b0, 32'h2222_2222);
        drain();
        glog.delete();
        gcyc.delete();

        // DMA locked burst against a continuously valid CPU (last grant was CPU).
        fork
            drive(0, MODE_LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h1111_1111);
            begin
                drive(1, MODE_LW, 32'h104, 32'h0, 1'b1, 1'b0, 32'h2222_2222);
                drive(1, MODE_SW, 32'h108, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
                drive(1, MODE_LW, 32'h108, 32'h0, 1'b0, 1'b0, 32'h3333_3333);
            end
        join
        drain();
        check_grants("t3_grant", 4, 8'b0111);

        // Rejected requests: misaligned, out of range, illegal mode.
        drive(0, MODE_LH, 32'h101, 32'h0, 1'b0, 1'b1, 32'h0);
        drive(0, MODE_SW, 32'h0010_0002, 32'h5555_5555, 1'b0, 1'b1, 32'h0);
        drive(1, MODE_LW, 32'h102, 32'h0, 1'b0, 1'b1, 32'h0);
        drive(1, 4'b1000, 32'h200, 32'h0, 1'b0, 1'b1, 32'h0);
        drain();
        chk("t4_err_hold", {31'h0, rsp_err}, 32'd1);
        chk("t4_mem_0x100", mem_word(32'h100), 32'h1111_1111);
        chk("t4_mem_alias_0x2", mem_word(32'h2), 32'h0);
        glog.delete();
        gcyc.delete();

        // Sign and zero extension of a byte load.
        drive(0, MODE_LB, 32'h20, 32'h0, 1'b0, 1'b0, 32'hFFFF_FF80);
        drive(1, MODE_LBU, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0000_0080);
        drain();
        chk("t5_rdata_hold", rsp_rdata, 32'h0000_0080);
        glog.delete();
        gcyc.delete();

        // Reset during the ACCESS cycle of a byte store.
        req_mode[0]  = MODE_SB;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'h0000_00AA;
        req_lock[0]  = 1'b0;
        req_valid[0] = 1'b1;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (req_ready[0]) got = 1'b1;
            end
            chk("t6_accept", {31'h0, got}, 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_access_mem_mode", {28'h0, mem_mode}, {28'h0, MODE_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", {30'h0, rsp_valid}, 32'd0);
        chk("t6_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("t6_rsp_rdata", rsp_rdata, 32'd0);
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_mem_wdata", mem_wdata, 32'd0);
        chk("t6_req_ready", {30'h0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_mem_0x40", {24'h0, mem[32'h40]}, 32'h0000_005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
